pixel_stream_tx: RTL

//  Plane-sequential pixel stream source: reads a stored RGB frame from a synchronous-read pixel

---
 rtl/pixel_stream_tx_pkg.sv | 24 ++
 rtl/pixel_stream_tx.sv | 122 ++++++++++++
 2 files changed

// File: rtl/pixel_stream_tx_pkg.sv
// Shared definitions for the plane-sequential pixel stream source.
// Color codes match the downstream statistics and denoise stages.
package pixel_stream_tx_pkg;

  localparam int unsigned MaxLog2Default = 20;

  typedef enum logic [1:0] {
    ColorRed   = 2'd0,
    ColorGreen = 2'd1,
    ColorBlue  = 2'd2
  } color_e;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRead  = 2'd1,
    StDrain = 2'd2,
    StDone  = 2'd3
  } state_e;

  function automatic logic [4:0] clamp_size(input logic [4:0] size, input logic [4:0] max_size);
    return (size > max_size) ? max_size : size;
  endfunction

endpackage

// File: rtl/pixel_stream_tx.sv
// Reads a stored RGB frame plane by plane (R, G, B) from a synchronous-read memory and
// emits it as a gapless valid/color/value/last stream with a fixed two-cycle latency.
module pixel_stream_tx
  import pixel_stream_tx_pkg::*;
#(
  parameter int unsigned MAX_LOG2 = MaxLog2Default,
  parameter int unsigned AW       = MAX_LOG2 + 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  input  logic [4:0]    size_i,
  output logic          rd_en_o,
  output logic [AW-1:0] rd_addr_o,
  input  logic [7:0]    rd_data_i,
  output logic          valid_o,
  output logic [1:0]    color_o,
  output logic [7:0]    value_o,
  output logic          last_o,
  output logic          busy_o,
  output logic          done_o
);

  // One extra bit so a full 2^MAX_LOG2 plane never overflows the index.
  localparam int unsigned IW = MAX_LOG2 + 1;
  localparam logic [4:0] MaxSize = 5'(MAX_LOG2);

  state_e         state_q, state_d;
  logic [4:0]     size_q;
  logic [1:0]     color_q;
  logic [IW-1:0]  idx_q;
  logic [IW-1:0]  plane_max;
  logic           drain_q;
  logic           at_end;
  logic           start_ok;

  logic           s1_valid_q;
  logic [1:0]     s1_color_q;
  logic           s1_last_q;

  assign plane_max = ~({IW{1'b1}} << size_q);
  assign at_end    = (idx_q == plane_max);
  assign start_ok  = (state_q == StIdle) && start_i;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start_i) state_d = StRead;
      StRead:  if (at_end && (color_q == ColorBlue)) state_d = StDrain;
      StDrain: if (drain_q) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    rd_en_o   = (state_q == StRead);
    rd_addr_o = '0;
    if (rd_en_o) begin
      rd_addr_o = AW'({color_q, idx_q[MAX_LOG2-1:0]});
    end
    busy_o = (state_q == StRead) || (state_q == StDrain);
    done_o = (state_q == StDone);
  end

  // Address/index generator
  always_ff @(posedge clk) begin
    if (rst) begin
      size_q  <= '0;
      color_q <= ColorRed;
      idx_q   <= '0;
      drain_q <= 1'b0;
    end else begin
      if (start_ok) begin
        size_q  <= clamp_size(size_i, MaxSize);
        color_q <= ColorRed;
        idx_q   <= '0;
      end else if (state_q == StRead) begin
        if (at_end) begin
          idx_q   <= '0;
          color_q <= color_q + 2'd1;
        end else begin
          idx_q <= idx_q + 1'b1;
        end
      end
      drain_q <= (state_q == StDrain) ? ~drain_q : 1'b0;
    end
  end

  // Stage 1 tracks the memory access; stage 2 captures the read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_color_q <= '0;
      s1_last_q  <= 1'b0;
      valid_o    <= 1'b0;
      color_o    <= '0;
      value_o    <= '0;
      last_o     <= 1'b0;
    end else begin
      s1_valid_q <= rd_en_o;
      s1_color_q <= rd_en_o ? color_q : 2'd0;
      s1_last_q  <= rd_en_o && at_end;
      valid_o    <= s1_valid_q;
      color_o    <= s1_valid_q ? s1_color_q : 2'd0;
      value_o    <= s1_valid_q ? rd_data_i : 8'd0;
      last_o     <= s1_valid_q && s1_last_q;
    end
  end

endmodule
